// File: rtl/bus_responder.sv
// CPU bus responder: 2 KiB RAM mirrored across $0000-$1FFF, a 4-byte timer block
// with an active-low interrupt, and an optional fixed wait-state generator on O_ready.
module bus_responder #(
  parameter int          RAM_BITS  = 11,
  parameter int          WAIT_CLKS = 0,
  parameter logic [15:0] TMR_BASE  = 16'h4020
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_addr,
  input  logic [7:0]  I_wr_data,
  input  logic        I_rdwr,
  output logic [7:0]  O_rd_data,
  output logic        O_ready,
  output logic        O_sel,
  output logic        O_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } wait_state_e;

  localparam bit         WAIT_EN = (WAIT_CLKS > 0);
  localparam logic [3:0] WAIT_M1 = WAIT_EN ? 4'(WAIT_CLKS - 1) : 4'd0;

  function automatic logic tmr_hit_f(input logic [15:0] a);
    logic [15:0] off;
    off = a - TMR_BASE;
    return (off[15:2] == 14'd0);
  endfunction

  function automatic logic mapped_f(input logic [15:0] a);
    return (a < 16'h2000) || tmr_hit_f(a);
  endfunction

  logic                phy2_q;
  logic                rise_s;
  logic                fall_s;
  logic [15:0]         addr_q;
  logic                rdwr_q;
  logic                sel_q;
  logic                rd_pend_q;
  logic                tmr_sel_s;
  logic [1:0]          tmr_idx_s;
  logic [RAM_BITS-1:0] ram_idx_s;
  logic                wr_commit_s;
  logic                ram_we_s;
  logic                tmr_we_s;
  logic [7:0]          ram_q [0:(2**RAM_BITS)-1];
  logic [7:0]          rd_val_s;
  logic [7:0]          rd_data_q, rd_data_d;
  wait_state_e         state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                ready_q, ready_d;
  logic [7:0]          reload_lo_q, reload_lo_d;
  logic [7:0]          reload_hi_q, reload_hi_d;
  logic                en_q, en_d;
  logic                ien_q, ien_d;
  logic                auto_q, auto_d;
  logic                exp_q, exp_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic                irq_q, irq_d;
  logic [15:0]         reload_s;
  logic                expire_s;

  assign rise_s      = I_phy2 & ~phy2_q;
  assign fall_s      = ~I_phy2 & phy2_q;
  assign tmr_sel_s   = tmr_hit_f(addr_q);
  assign tmr_idx_s   = addr_q[1:0] - TMR_BASE[1:0];
  assign ram_idx_s   = addr_q[RAM_BITS-1:0];
  assign wr_commit_s = fall_s & sel_q & ~rdwr_q;
  assign ram_we_s    = wr_commit_s & ~tmr_sel_s;
  assign tmr_we_s    = wr_commit_s & tmr_sel_s;
  assign reload_s    = {reload_hi_q, reload_lo_q};
  // A zero count with EN set also expires, covering a reload value of 0.
  assign expire_s    = fall_s & en_q & (tcnt_q <= 16'd1);

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      phy2_q    <= 1'b0;
      addr_q    <= 16'd0;
      rdwr_q    <= 1'b1;
      sel_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      phy2_q    <= I_phy2;
      rd_pend_q <= rise_s;
      if (rise_s) begin
        addr_q <= I_addr;
        rdwr_q <= I_rdwr;
        sel_q  <= mapped_f(I_addr);
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge I_clock) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= I_wr_data;
    end
  end

  always_comb begin
    rd_val_s = ram_q[ram_idx_s];
    if (tmr_sel_s) begin
      case (tmr_idx_s)
        2'd0:    rd_val_s = reload_lo_q;
        2'd1:    rd_val_s = reload_hi_q;
        2'd2:    rd_val_s = {5'd0, auto_q, ien_q, en_q};
        2'd3:    rd_val_s = {7'd0, exp_q};
        default: rd_val_s = 8'd0;
      endcase
    end else begin
      rd_val_s = ram_q[ram_idx_s];
    end
    rd_data_d = rd_data_q;
    if (rd_pend_q && rdwr_q && sel_q) begin
      rd_data_d = rd_val_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (WAIT_EN && rise_s && mapped_f(I_addr)) begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_M1;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_HOLD;
          ready_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (fall_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    reload_lo_d = reload_lo_q;
    reload_hi_d = reload_hi_q;
    en_d        = en_q;
    ien_d       = ien_q;
    auto_d      = auto_q;
    exp_d       = exp_q;
    tcnt_d      = tcnt_q;
    if (expire_s) begin
      exp_d = 1'b1;
      if (auto_q) begin
        tcnt_d = reload_s;
      end else begin
        en_d   = 1'b0;
        tcnt_d = 16'd0;
      end
    end else if (fall_s && en_q) begin
      tcnt_d = tcnt_q - 16'd1;
    end else begin
      tcnt_d = tcnt_q;
    end
    // Register writes override the countdown; a pending expiry still sets EXP.
    if (tmr_we_s) begin
      case (tmr_idx_s)
        2'd0: reload_lo_d = I_wr_data;
        2'd1: reload_hi_d = I_wr_data;
        2'd2: begin
          en_d   = I_wr_data[0];
          ien_d  = I_wr_data[1];
          auto_d = I_wr_data[2];
          tcnt_d = I_wr_data[0] ? reload_s : tcnt_q;
        end
        2'd3:    exp_d = I_wr_data[0] ? expire_s : (exp_q | expire_s);
        default: reload_lo_d = reload_lo_q;
      endcase
    end else begin
      reload_lo_d = reload_lo_q;
    end
    irq_d = ~(exp_d & ien_d);
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      rd_data_q   <= 8'd0;
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      ready_q     <= 1'b1;
      reload_lo_q <= 8'd0;
      reload_hi_q <= 8'd0;
      en_q        <= 1'b0;
      ien_q       <= 1'b0;
      auto_q      <= 1'b0;
      exp_q       <= 1'b0;
      tcnt_q      <= 16'd0;
      irq_q       <= 1'b1;
    end else begin
      rd_data_q   <= rd_data_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ready_q     <= ready_d;
      reload_lo_q <= reload_lo_d;
      reload_hi_q <= reload_hi_d;
      en_q        <= en_d;
      ien_q       <= ien_d;
      auto_q      <= auto_d;
      exp_q       <= exp_d;
      tcnt_q      <= tcnt_d;
      irq_q       <= irq_d;
    end
  end

  assign O_rd_data = rd_data_q;
  assign O_ready   = ready_q;
  assign O_sel     = sel_q;
  assign O_irq     = irq_q;

endmodule
